dmem_host_ctrl: RTL and testbench

- Host-side sequencer for the dual-SRAM data memory.
- Accepts host commands:
  - LOAD: stream words into memory.
  - DUMP: stream words out of memory.
  - RUN: hand memory to the micro-engine.
- Drives the memory's io write/read ports and owns the `busy` signal that switches memory ownership between io and the datapath.
- Sits between the host interface and the data memory; the micro-engine sees only `run_start`/`run_done`.

---
 rtl/dmem_ctrl_pkg.sv | 32 +++
 rtl/dmem_host_ctrl_if.sv | 41 ++++
 rtl/dmem_out_fifo.sv | 44 ++++
 rtl/dmem_host_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dmem_host_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared types and constants for the data-memory host sequencer
`ifndef RFSZLOG2
`define RFSZLOG2 4
`endif
`ifndef WORDSZ
`define WORDSZ 16
`endif

package dmem_ctrl_pkg;
   localparam int AW_DEF     = `RFSZLOG2;
   localparam int DW_DEF     = `WORDSZ;
   localparam int FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'd0,
      OP_DUMP  = 2'd1,
      OP_RUN   = 2'd2,
      OP_CLEAR = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DUMP,
      ST_RUN_REQ,
      ST_RUN,
`ifdef DMEM_CLEAR_EN
      ST_CLEAR,
`endif
      ST_DONE
   } state_e;
endpackage

// File: rtl/dmem_host_ctrl_if.sv
// rtl/dmem_host_ctrl_if.sv - host command, data streams, engine handshake and memory io port bundle
interface dmem_host_ctrl_if #(
   parameter int AW = dmem_ctrl_pkg::AW_DEF,
   parameter int DW = dmem_ctrl_pkg::DW_DEF
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr;
   logic [AW:0]   cmd_len;
   logic          cmd_done;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          run_start;
   logic          run_done;
   logic          busy;
   logic          wen_io;
   logic [AW-1:0] waddr_io;
   logic [DW-1:0] data_in;
   logic          ren_io;
   logic [AW-1:0] raddr_io;
   logic [DW-1:0] data_out;

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_len, in_valid, in_data,
             out_ready, run_done, data_out,
      output cmd_ready, cmd_done, in_ready, out_valid, out_data, run_start,
             busy, wen_io, waddr_io, data_in, ren_io, raddr_io
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_len, in_valid, in_data,
             out_ready, run_done, data_out,
      input  cmd_ready, cmd_done, in_ready, out_valid, out_data, run_start,
             busy, wen_io, waddr_io, data_in, ren_io, raddr_io
   );
endinterface

// File: rtl/dmem_out_fifo.sv
// rtl/dmem_out_fifo.sv - two-entry synchronous FIFO buffering DUMP read data
module dmem_out_fifo
   import dmem_ctrl_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [1:0]    count,
   output logic [DW-1:0] head
);
   logic [DW-1:0] mem [FIFO_DEPTH];
   logic          rd_ptr;
   logic          wr_ptr;
   logic          pop_ok;
   logic          push_ok;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign pop_ok  = pop && (count != 2'd0);
   assign push_ok = push && ((count != 2'(FIFO_DEPTH)) || pop_ok);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end
endmodule

// File: rtl/dmem_host_ctrl.sv
// rtl/dmem_host_ctrl.sv - host LOAD/DUMP/RUN sequencer owning the dual-SRAM io ports and busy
// Optional CLEAR command (op 3 zero-fill) is built when DMEM_CLEAR_EN is defined.
module dmem_host_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   dmem_host_ctrl_if.master bus
);
   state_e        state;
   logic [AW-1:0] addr;
   logic [AW:0]   rem;
   logic          inflight;
   logic          cmd_ready_q;
   logic          cmd_done_q;
   logic          run_start_q;
   logic          busy_q;
   logic [1:0]    fifo_count;
   logic [DW-1:0] fifo_head;
   logic [1:0]    occ;
   logic          pop;
   logic          ren;
   logic          wen;
   logic [DW-1:0] wdata;
   logic          last;

   assign last = (rem == (AW+1)'(1));
   assign pop  = (fifo_count != 2'd0) && bus.out_ready;
   assign occ  = fifo_count + {1'b0, inflight};

   // A pop this cycle frees a slot, which keeps DUMP streaming at one word per cycle.
   always_comb begin
      ren = (state == ST_DUMP) && (rem != '0) &&
            ((occ < 2'd2) || ((occ == 2'd2) && pop));
   end

   always_comb begin
      wen   = 1'b0;
      wdata = bus.in_data;
      if (state == ST_LOAD) wen = bus.in_valid;
`ifdef DMEM_CLEAR_EN
      if (state == ST_CLEAR) begin
         wen   = 1'b1;
         wdata = '0;
      end
`endif
   end

   dmem_out_fifo #(.DW(DW)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (state == ST_IDLE),
      .push      (inflight),
      .push_data (bus.data_out),
      .pop       (pop),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.cmd_done  = cmd_done_q;
   assign bus.run_start = run_start_q;
   assign bus.busy      = busy_q;
   assign bus.in_ready  = (state == ST_LOAD);
   assign bus.out_valid = (fifo_count != 2'd0);
   assign bus.out_data  = fifo_head;
   assign bus.wen_io    = wen;
   assign bus.waddr_io  = addr;
   assign bus.data_in   = wdata;
   assign bus.ren_io    = ren;
   assign bus.raddr_io  = addr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         addr        <= '0;
         rem         <= '0;
         inflight    <= 1'b0;
         cmd_ready_q <= 1'b1;
         cmd_done_q  <= 1'b0;
         run_start_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         inflight <= ren;
         case (state)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  addr        <= bus.cmd_addr;
                  rem         <= bus.cmd_len;
                  cmd_ready_q <= 1'b0;
                  case (bus.cmd_op)
                     OP_LOAD, OP_DUMP: begin
                        if (bus.cmd_len == '0) begin
                           state      <= ST_DONE;
                           cmd_done_q <= 1'b1;
                        end else begin
                           state <= (bus.cmd_op == OP_LOAD) ? ST_LOAD : ST_DUMP;
                        end
                     end
                     OP_RUN: begin
                        state       <= ST_RUN_REQ;
                        busy_q      <= 1'b1;
                        run_start_q <= 1'b1;
                     end
                     default: begin
`ifdef DMEM_CLEAR_EN
                        if (bus.cmd_len == '0) begin
                           state      <= ST_DONE;
                           cmd_done_q <= 1'b1;
                        end else begin
                           state <= ST_CLEAR;
                        end
`else
                        state      <= ST_DONE;
                        cmd_done_q <= 1'b1;
`endif
                     end
                  endcase
               end
            end
            ST_LOAD: begin
               if (wen) begin
                  addr <= addr + 1'b1;
                  rem  <= rem - 1'b1;
                  if (last) begin
                     state      <= ST_DONE;
                     cmd_done_q <= 1'b1;
                  end
               end
            end
`ifdef DMEM_CLEAR_EN
            ST_CLEAR: begin
               addr <= addr + 1'b1;
               rem  <= rem - 1'b1;
               if (last) begin
                  state      <= ST_DONE;
                  cmd_done_q <= 1'b1;
               end
            end
`endif
            ST_DUMP: begin
               if (ren) begin
                  addr <= addr + 1'b1;
                  rem  <= rem - 1'b1;
               end
               if ((rem == '0) && !inflight && (fifo_count == 2'd0)) begin
                  state      <= ST_DONE;
                  cmd_done_q <= 1'b1;
               end
            end
            ST_RUN_REQ: begin
               run_start_q <= 1'b0;
               state       <= ST_RUN;
            end
            ST_RUN: begin
               if (bus.run_done) begin
                  state      <= ST_DONE;
                  busy_q     <= 1'b0;
                  cmd_done_q <= 1'b1;
               end
            end
            ST_DONE: begin
               cmd_done_q  <= 1'b0;
               cmd_ready_q <= 1'b1;
               state       <= ST_IDLE;
            end
            default: begin
               state       <= ST_IDLE;
               cmd_ready_q <= 1'b1;
               cmd_done_q  <= 1'b0;
               run_start_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_host_ctrl.sv
// tb/tb_dmem_host_ctrl.sv - directed self-checking bench for dmem_host_ctrl
module tb_dmem_host_ctrl;
   import dmem_ctrl_pkg::*;
   localparam int AW = AW_DEF;
   localparam int DW = DW_DEF;
   localparam int NW = 1 << AW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_host_ctrl_if #(.AW(AW), .DW(DW)) bus ();
   dmem_host_ctrl #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int nchk = 0;
   int nerr = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rdy_fix = 1'b1;
   logic       toggle_en = 1'b0;
   logic [1:0] tk = 2'd0;
   logic [3:0] pat = 4'b1001;
   always @(posedge clk) if (toggle_en) tk <= tk + 2'd1;
   assign bus.out_ready = toggle_en ? pat[tk] : rdy_fix;

   // memory model: registered read, address 0 reads back as zero
   logic [DW-1:0] mem [NW];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NW; i++) mem[i] <= (i == 0) ? '0 : DW'(32'h1000 + i);
      end else begin
         if (bus.wen_io) mem[bus.waddr_io] <= (bus.waddr_io == '0) ? '0 : bus.data_in;
      end
      if (bus.ren_io) bus.data_out <= mem[bus.raddr_io];
   end

   int wa[$], wd[$], wc[$], ra[$], rc[$], od[$], oc[$];
   int done_cnt = 0, done_cyc = 0, busy_cnt = 0, io_busy_viol = 0;
   int credit_viol = 0, rs_cnt = 0, outstanding = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         outstanding = 0;
      end else begin
         if (bus.wen_io) begin wa.push_back(int'(bus.waddr_io)); wd.push_back(int'(bus.data_in)); wc.push_back(cyc); end
         if (bus.ren_io) begin
            ra.push_back(int'(bus.raddr_io)); rc.push_back(cyc);
            if (outstanding - int'(bus.out_valid && bus.out_ready) >= 2) credit_viol++;
         end
         if (bus.out_valid && bus.out_ready) begin od.push_back(int'(bus.out_data)); oc.push_back(cyc); end
         outstanding = outstanding + int'(bus.ren_io) - int'(bus.out_valid && bus.out_ready);
         if (bus.cmd_done) begin done_cnt++; done_cyc = cyc; end
         if (bus.busy) begin busy_cnt++; if (bus.wen_io || bus.ren_io) io_busy_viol++; end
         if (bus.run_start) rs_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   int acc_cyc;
   task automatic send_cmd(input logic [1:0] op, input int a, input int l);
      bit ok = 0;
      int n = 0;
      bus.cmd_valid = 1'b1; bus.cmd_op = op;
      bus.cmd_addr = AW'(a); bus.cmd_len = (AW+1)'(l);
      while (!ok && n < 50) begin
         @(negedge clk);
         if (bus.cmd_ready) begin ok = 1; acc_cyc = cyc; end
         @(posedge clk); #1;
         n++;
      end
      bus.cmd_valid = 1'b0;
      if (!ok) chk("cmd_accept_timeout", 0, 1);
   endtask

   task automatic feed(input logic [DW-1:0] w, input int gap);
      bit hs = 0;
      int n = 0;
      bus.in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
      bus.in_valid = 1'b1; bus.in_data = w;
      while (!hs && n < 20) begin
         @(negedge clk); hs = bus.in_ready;
         @(posedge clk); #1; n++;
      end
      bus.in_valid = 1'b0;
      if (!hs) chk("in_handshake_timeout", 0, 1);
   endtask

   task automatic wait_done(input int budget);
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < budget) begin @(posedge clk); #1; n++; end
      if (done_cnt == d0) chk("cmd_done_timeout", 0, 1);
   endtask

   localparam logic [DW-1:0] WA = DW'(16'hA1A1), WB = DW'(16'hB2B2), WC = DW'(16'hC3C3);
   localparam logic [DW-1:0] WE = DW'(16'hE5E5), WF = DW'(16'hF6F6);

   initial begin
      int w0, r0, o0, d0, b0, s, n;
      logic [DW-1:0] exp4 [4];
      bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_addr = 0; bus.cmd_len = 0;
      bus.in_valid = 0; bus.in_data = 0; bus.run_done = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_cmd_done", bus.cmd_done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_io_en", {bus.wen_io, bus.ren_io}, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // LOAD 5..7 with gaps on in_valid
      w0 = wa.size(); b0 = busy_cnt; d0 = done_cnt;
      send_cmd(OP_LOAD, 5, 3);
      feed(WA, 1); feed(WB, 0); feed(WC, 2);
      wait_done(20);
      chk("load_nwrites", wa.size() - w0, 3);
      for (int i = 0; i < 3; i++) chk("load_waddr", wa[w0+i], 5 + i);
      chk("load_data0", wd[w0], WA); chk("load_data1", wd[w0+1], WB); chk("load_data2", wd[w0+2], WC);
      chk("load_done_latency", done_cyc - wc[w0+2], 1);
      chk("load_busy", busy_cnt - b0, 0);
      repeat (2) @(posedge clk); #1;
      chk("load_done_pulses", done_cnt - d0, 1);

      // DUMP 5..7 at full rate
      r0 = ra.size(); o0 = od.size();
      send_cmd(OP_DUMP, 5, 3);
      wait_done(50);
      chk("dump_nwords", od.size() - o0, 3);
      chk("dump_w0", od[o0], WA); chk("dump_w1", od[o0+1], WB); chk("dump_w2", od[o0+2], WC);
      for (int i = 0; i < 3; i++) chk("dump_raddr", ra[r0+i], 5 + i);
      chk("dump_ren_b2b_01", rc[r0+1] - rc[r0], 1);
      chk("dump_ren_b2b_12", rc[r0+2] - rc[r0+1], 1);
      chk("dump_pop_b2b_01", oc[o0+1] - oc[o0], 1);
      chk("dump_pop_b2b_12", oc[o0+2] - oc[o0+1], 1);
      chk("dump_done_after_pop", done_cyc > oc[o0+2], 1);

      // DUMP 4..7 with out_ready pattern 1,0,0,1
      exp4[0] = DW'(16'h1004); exp4[1] = WA; exp4[2] = WB; exp4[3] = WC;
      r0 = credit_viol; o0 = od.size();
      toggle_en = 1'b1;
      send_cmd(OP_DUMP, 4, 4);
      wait_done(80);
      toggle_en = 1'b0;
      chk("tog_nwords", od.size() - o0, 4);
      for (int i = 0; i < 4; i++) chk("tog_word", od[o0+i], exp4[i]);
      chk("tog_credit", credit_viol - r0, 0);

      // LOAD wrapping past the top address, then LOAD len 0
      w0 = wa.size();
      send_cmd(OP_LOAD, NW - 1, 2);
      feed(WE, 0); feed(WF, 1);
      wait_done(20);
      chk("wrap_nwrites", wa.size() - w0, 2);
      chk("wrap_addr0", wa[w0], NW - 1);
      chk("wrap_addr1", wa[w0+1], 0);
      w0 = wa.size();
      send_cmd(OP_LOAD, 3, 0);
      wait_done(5);
      chk("len0_latency", done_cyc - acc_cyc, 1);
      chk("len0_nwrites", wa.size() - w0, 0);

      // run_done while idle is ignored
      d0 = done_cnt;
      bus.run_done = 1'b1; @(posedge clk); #1 bus.run_done = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("idle_run_done", done_cnt - d0, 0);

      // RUN with run_done 10 cycles after run_start
      b0 = busy_cnt; r0 = io_busy_viol; o0 = rs_cnt;
      send_cmd(OP_RUN, 0, 0);
      s = -1; n = 0;
      while (s < 0 && n < 10) begin
         @(negedge clk);
         if (bus.run_start) s = cyc;
         n++;
      end
      if (s < 0) chk("run_start_timeout", 0, 1);
      repeat (10) @(posedge clk);
      #1 bus.run_done = 1'b1;
      @(posedge clk); #1 bus.run_done = 1'b0;
      wait_done(20);
      chk("run_busy_cycles", busy_cnt - b0, 11);
      chk("run_io_quiet", io_busy_viol - r0, 0);
      chk("run_start_pulses", rs_cnt - o0, 1);
      chk("run_done_cycle", done_cyc - s, 11);
      @(negedge clk);
      chk("run_cmd_ready", bus.cmd_ready, 1);
      chk("run_busy_after", bus.busy, 0);
      @(posedge clk); #1;

      // reset in the middle of a stalled DUMP
      rdy_fix = 1'b0; d0 = done_cnt;
      send_cmd(OP_DUMP, 5, 3);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_cmd_ready", bus.cmd_ready, 1);
      chk("abort_ren", bus.ren_io, 0);
      rdy_fix = 1'b1;
      repeat (5) @(posedge clk); #1;
      chk("abort_no_done", done_cnt - d0, 0);

      // op 3: zero-fill when built in, otherwise a no-op
      w0 = wa.size();
      send_cmd(OP_CLEAR, 0, 4);
      wait_done(20);
`ifdef DMEM_CLEAR_EN
      chk("clear_nwrites", wa.size() - w0, 4);
      for (int i = 0; i < 4; i++) begin
         chk("clear_addr", wa[w0+i], i);
         chk("clear_data", wd[w0+i], 0);
      end
`else
      chk("clear_noop_nwrites", wa.size() - w0, 0);
      chk("clear_noop_latency", done_cyc - acc_cyc, 1);
`endif

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
